// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer slice.
package rob_pkg;

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_ALLOC_W  = 2;
  localparam int DEF_CMPL_W   = 3;
  localparam int DEF_RETIRE_W = 2;
  localparam int DEF_PREG_W   = 6;
  localparam int DEF_DATA_W   = 32;

  localparam logic DEST_REG = 1'b0;
  localparam logic DEST_MEM = 1'b1;

  typedef struct packed {
    logic                  v;
    logic                  is_store;
    logic [DEF_PREG_W-1:0] pd;
    logic [DEF_PREG_W-1:0] old_pd;
    logic [DEF_DATA_W-1:0] result;
    logic                  comp;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / retire bundle of the reorder buffer.
interface reorder_buffer_if #(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 2,
  parameter int CMPL_W   = 3,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ALLOC_W-1:0]             alloc_valid;
  logic                           alloc_ready;
  logic [ALLOC_W-1:0]             alloc_is_store;
  logic [ALLOC_W-1:0][PREG_W-1:0] alloc_pd;
  logic [ALLOC_W-1:0][PREG_W-1:0] alloc_old_pd;
  logic [ALLOC_W-1:0][IDX_W-1:0]  alloc_idx;

  logic [CMPL_W-1:0]              cmpl_valid;
  logic [CMPL_W-1:0][IDX_W-1:0]   cmpl_idx;
  logic [CMPL_W-1:0][DATA_W-1:0]  cmpl_result;

  logic                           flush;

  logic [RETIRE_W-1:0]              ret_valid;
  logic [RETIRE_W-1:0]              ret_is_store;
  logic [RETIRE_W-1:0][PREG_W-1:0]  ret_pd;
  logic [RETIRE_W-1:0][PREG_W-1:0]  ret_old_pd;
  logic [RETIRE_W-1:0][DATA_W-1:0]  ret_result;

  logic [IDX_W:0]                 count;
  logic                           empty;
  logic                           full;

  modport master (
    output alloc_valid, alloc_is_store, alloc_pd, alloc_old_pd,
    output cmpl_valid, cmpl_idx, cmpl_result, flush,
    input  alloc_ready, alloc_idx,
    input  ret_valid, ret_is_store, ret_pd, ret_old_pd, ret_result,
    input  count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_is_store, alloc_pd, alloc_old_pd,
    input  cmpl_valid, cmpl_idx, cmpl_result, flush,
    output alloc_ready, alloc_idx,
    output ret_valid, ret_is_store, ret_pd, ret_old_pd, ret_result,
    output count, empty, full
  );

endinterface

// File: rtl/rob_retire_select.sv
// Counts leading completed entries from head, capped at RETIRE_W.
module rob_retire_select #(
  parameter int DEPTH    = 16,
  parameter int RETIRE_W = 2,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int NRET_W   = $clog2(RETIRE_W + 1)
) (
  input  logic [DEPTH-1:0]    done_i,
  input  logic [IDX_W-1:0]    head_i,
  output logic [NRET_W-1:0]   nret_o,
  output logic [RETIRE_W-1:0] mask_o
);

  logic             run;
  logic [IDX_W-1:0] idx;

  // The run of completed entries breaks at the first incomplete one.
  always_comb begin
    mask_o = '0;
    nret_o = '0;
    run    = 1'b1;
    idx    = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      idx       = head_i + IDX_W'(k);
      run       = run & done_i[idx];
      mask_o[k] = run;
      if (run) nret_o = nret_o + NRET_W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete, in-order retire.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ALLOC_W  = DEF_ALLOC_W,
  parameter int CMPL_W   = DEF_CMPL_W,
  parameter int RETIRE_W = DEF_RETIRE_W,
  parameter int PREG_W   = DEF_PREG_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int NRET_W = $clog2(RETIRE_W + 1);

  typedef struct packed {
    logic              v;
    logic              is_store;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic [DATA_W-1:0] result;
    logic              comp;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, nalloc;
  logic             alloc_ok;
  logic [DEPTH-1:0] done;
  logic [NRET_W-1:0]   nret;
  logic [RETIRE_W-1:0] ret_mask;
  logic [IDX_W-1:0]    ridx, cidx, aidx;

  logic [RETIRE_W-1:0]             ret_valid_q, ret_valid_d;
  logic [RETIRE_W-1:0]             ret_is_store_q, ret_is_store_d;
  logic [RETIRE_W-1:0][PREG_W-1:0] ret_pd_q, ret_pd_d;
  logic [RETIRE_W-1:0][PREG_W-1:0] ret_old_pd_q, ret_old_pd_d;
  logic [RETIRE_W-1:0][DATA_W-1:0] ret_result_q, ret_result_d;

  // Back-pressure looks only at registered occupancy; same-cycle retirement is not credited.
  assign alloc_ok = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ALLOC_W);

  always_comb begin
    nalloc = '0;
    if (alloc_ok) begin
      for (int i = 0; i < ALLOC_W; i++) nalloc = nalloc + CNT_W'(bus.alloc_valid[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < ALLOC_W; i++) bus.alloc_idx[i] = tail_q + IDX_W'(i);
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) done[e] = ent_q[e].v & ent_q[e].comp;
  end

  rob_retire_select #(
    .DEPTH    (DEPTH),
    .RETIRE_W (RETIRE_W)
  ) u_retire_select (
    .done_i (done),
    .head_i (head_q),
    .nret_o (nret),
    .mask_o (ret_mask)
  );

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    ret_valid_d    = '0;
    ret_is_store_d = ret_is_store_q;
    ret_pd_d       = ret_pd_q;
    ret_old_pd_d   = ret_old_pd_q;
    ret_result_d   = ret_result_q;
    ridx           = '0;
    cidx           = '0;
    aidx           = '0;
    if (bus.flush) begin
      for (int e = 0; e < DEPTH; e++) ent_d[e].v = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < RETIRE_W; k++) begin
        if (ret_mask[k]) begin
          ridx              = head_q + IDX_W'(k);
          ret_is_store_d[k] = ent_q[ridx].is_store;
          ret_pd_d[k]       = ent_q[ridx].pd;
          ret_old_pd_d[k]   = ent_q[ridx].old_pd;
          ret_result_d[k]   = ent_q[ridx].result;
          ent_d[ridx].v     = 1'b0;
        end
      end
      ret_valid_d = ret_mask;
      // Later lanes overwrite earlier ones targeting the same entry.
      for (int l = 0; l < CMPL_W; l++) begin
        cidx = bus.cmpl_idx[l];
        if (bus.cmpl_valid[l] && ent_q[cidx].v) begin
          ent_d[cidx].result = bus.cmpl_result[l];
          ent_d[cidx].comp   = 1'b1;
        end
      end
      for (int i = 0; i < ALLOC_W; i++) begin
        aidx = tail_q + IDX_W'(i);
        if (alloc_ok && bus.alloc_valid[i]) begin
          ent_d[aidx].v        = 1'b1;
          ent_d[aidx].is_store = bus.alloc_is_store[i];
          ent_d[aidx].pd       = bus.alloc_pd[i];
          ent_d[aidx].old_pd   = bus.alloc_old_pd[i];
          ent_d[aidx].comp     = 1'b0;
        end
      end
      head_d  = head_q + IDX_W'(nret);
      tail_d  = tail_q + IDX_W'(nalloc);
      count_d = count_q + nalloc - CNT_W'(nret);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      ret_valid_q    <= '0;
      ret_is_store_q <= '0;
      ret_pd_q       <= '0;
      ret_old_pd_q   <= '0;
      ret_result_q   <= '0;
      for (int e = 0; e < DEPTH; e++) ent_q[e].v <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      ret_valid_q    <= ret_valid_d;
      ret_is_store_q <= ret_is_store_d;
      ret_pd_q       <= ret_pd_d;
      ret_old_pd_q   <= ret_old_pd_d;
      ret_result_q   <= ret_result_d;
      ent_q          <= ent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      for (int l = 0; l < CMPL_W; l++) begin
        if (bus.cmpl_valid[l]) begin
          assert (ent_q[bus.cmpl_idx[l]].v)
            else $warning("reorder_buffer: completion to idle entry %0d dropped", bus.cmpl_idx[l]);
        end
      end
    end
  end

  assign bus.alloc_ready  = alloc_ok;
  assign bus.ret_valid    = ret_valid_q;
  assign bus.ret_is_store = ret_is_store_q;
  assign bus.ret_pd       = ret_pd_q;
  assign bus.ret_old_pd   = ret_old_pd_q;
  assign bus.ret_result   = ret_result_q;
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a program-order queue model.
module tb_reorder_buffer;
  import rob_pkg::*;

  localparam int DEPTH = 16, ALLOC_W = 2, CMPL_W = 3, RETIRE_W = 2, PREG_W = 6, DATA_W = 32;
  localparam int PKT_W = 2 + 2 * PREG_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .CMPL_W(CMPL_W),
                      .RETIRE_W(RETIRE_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) bus ();

  reorder_buffer #(.DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .CMPL_W(CMPL_W),
                   .RETIRE_W(RETIRE_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: entries in program order; mq[0] sits at ROB index mhead.
  rob_entry_t mq[$];
  int         mhead = 0;
  logic [1:0] exp_rv = '0;
  rob_entry_t exp_ret [2];

  always @(posedge clk)
    if (!rst)
      assert ((bus.alloc_valid & (bus.alloc_valid + 2'd1)) == '0)
        else $error("non-contiguous alloc_valid %b", bus.alloc_valid);

  function automatic logic [7:0] exp_status();
    return {5'(mq.size()), mq.size() == 0, mq.size() == DEPTH, mq.size() <= DEPTH - ALLOC_W};
  endfunction

  function automatic logic [7:0] obs_status();
    return {bus.count, bus.empty, bus.full, bus.alloc_ready};
  endfunction

  function automatic logic [7:0] exp_aidx();
    int t;
    t = (mhead + mq.size()) % DEPTH;
    return {4'((t + 1) % DEPTH), 4'(t)};
  endfunction

  function automatic logic [2*PKT_W-1:0] obs_ret();
    logic [2*PKT_W-1:0] p;
    p = '0;
    for (int k = 0; k < RETIRE_W; k++)
      if (bus.ret_valid[k] === 1'b1)
        p[k*PKT_W +: PKT_W] = {1'b1, bus.ret_is_store[k], bus.ret_pd[k], bus.ret_old_pd[k], bus.ret_result[k]};
    return p;
  endfunction

  function automatic logic [2*PKT_W-1:0] exp_ret_pkt();
    logic [2*PKT_W-1:0] p;
    p = '0;
    for (int k = 0; k < RETIRE_W; k++)
      if (exp_rv[k])
        p[k*PKT_W +: PKT_W] = {1'b1, exp_ret[k].is_store, exp_ret[k].pd, exp_ret[k].old_pd, exp_ret[k].result};
    return p;
  endfunction

  task automatic idle();
    bus.alloc_valid    = '0;
    bus.alloc_is_store = '0;
    bus.alloc_pd       = '0;
    bus.alloc_old_pd   = '0;
    bus.cmpl_valid     = '0;
    bus.cmpl_idx       = '0;
    bus.cmpl_result    = '0;
    bus.flush          = 1'b0;
  endtask

  task automatic drive_alloc(input logic [1:0] v, input int pd0, input int opd0);
    bus.alloc_valid     = v;
    bus.alloc_is_store  = 2'b00;
    bus.alloc_pd[0]     = 6'(pd0);
    bus.alloc_pd[1]     = 6'(pd0 + 1);
    bus.alloc_old_pd[0] = 6'(opd0);
    bus.alloc_old_pd[1] = 6'(opd0 + 1);
  endtask

  task automatic drive_cmpl(input int lane, input int idx, input logic [31:0] res);
    bus.cmpl_valid[lane]  = 1'b1;
    bus.cmpl_idx[lane]    = 4'(idx);
    bus.cmpl_result[lane] = res;
  endtask

  // Advance the model by one cycle with the inputs currently driven, then clock the DUT.
  task automatic step();
    int n, j;
    logic ready;
    rob_entry_t e;
    if (rst) begin
      mq.delete(); mhead = 0; exp_rv = '0;
      for (int k = 0; k < RETIRE_W; k++) exp_ret[k] = '0;
    end else if (bus.flush) begin
      mq.delete(); mhead = 0; exp_rv = '0;
    end else begin
      n = 0;
      while (n < RETIRE_W && n < mq.size() && mq[n].comp == 1'b1) n++;
      exp_rv = '0;
      for (int k = 0; k < n; k++) begin exp_ret[k] = mq[k]; exp_rv[k] = 1'b1; end
      for (int l = 0; l < CMPL_W; l++)
        if (bus.cmpl_valid[l]) begin
          j = (int'(bus.cmpl_idx[l]) - mhead + DEPTH) % DEPTH;
          if (j < mq.size()) begin mq[j].result = bus.cmpl_result[l]; mq[j].comp = 1'b1; end
        end
      ready = (mq.size() <= DEPTH - ALLOC_W);
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      mhead = (mhead + n) % DEPTH;
      if (ready)
        for (int i = 0; i < ALLOC_W; i++)
          if (bus.alloc_valid[i]) begin
            e = '0; e.v = 1'b1; e.is_store = bus.alloc_is_store[i];
            e.pd = bus.alloc_pd[i]; e.old_pd = bus.alloc_old_pd[i];
            mq.push_back(e);
          end
    end
    @(posedge clk); #1;
  endtask

  task automatic hard_reset();
    idle(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    hard_reset();
    checks++;
    if (obs_status() !== {5'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", obs_status(), {5'd0, 3'b101});
    end
    checks++;
    if ({bus.ret_valid, bus.ret_is_store, bus.ret_pd, bus.ret_old_pd, bus.ret_result} !== '0) begin
      failures++; $display("FAIL reset_ret got valid=%b pd=%h result=%h exp all zero", bus.ret_valid, bus.ret_pd, bus.ret_result);
    end
    checks++;
    if (bus.alloc_idx !== 8'h10) begin
      failures++; $display("FAIL reset_alloc_idx got=%h exp=10", bus.alloc_idx);
    end
  endtask

  task automatic test_in_order();
    hard_reset();
    drive_alloc(2'b11, 32, 5); step();
    idle(); drive_cmpl(0, 0, 32'h11); drive_cmpl(1, 1, 32'h22); step();
    checks++;
    if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL inorder_early got=%b exp=00", bus.ret_valid); end
    idle(); step();
    checks++;
    if (bus.ret_valid !== 2'b11) begin failures++; $display("FAIL inorder_valid got=%b exp=11", bus.ret_valid); end
    checks++;
    if ({bus.ret_old_pd, bus.ret_pd} !== {6'd6, 6'd5, 6'd33, 6'd32}) begin
      failures++; $display("FAIL inorder_pd got old=%h pd=%h exp old=6/5 pd=33/32", bus.ret_old_pd, bus.ret_pd);
    end
    checks++;
    if (bus.ret_result !== {32'h22, 32'h11}) begin
      failures++; $display("FAIL inorder_result got=%h exp=%h", bus.ret_result, {32'h22, 32'h11});
    end
    step();
    checks++;
    if (bus.ret_valid !== 2'b00 || obs_status() !== exp_status()) begin
      failures++; $display("FAIL inorder_after got valid=%b status=%h exp valid=00 status=%h", bus.ret_valid, obs_status(), exp_status());
    end
  endtask

  task automatic test_out_of_order();
    hard_reset();
    drive_alloc(2'b11, 10, 20); step();
    drive_alloc(2'b11, 12, 22); step();
    idle(); drive_cmpl(0, 3, 32'h33); drive_cmpl(1, 2, 32'h32); drive_cmpl(2, 1, 32'h31); step();
    idle();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL ooo_blocked cycle=%0d got=%b exp=00", c, bus.ret_valid); end
      if (c < 2) step();
    end
    drive_cmpl(0, 0, 32'h30); step(); idle(); step();
    checks++;
    if (bus.ret_valid !== 2'b11 || bus.ret_result !== {32'h31, 32'h30}) begin
      failures++; $display("FAIL ooo_first got valid=%b result=%h exp valid=11 result=%h", bus.ret_valid, bus.ret_result, {32'h31, 32'h30});
    end
    step();
    checks++;
    if (bus.ret_valid !== 2'b11 || bus.ret_result !== {32'h33, 32'h32}) begin
      failures++; $display("FAIL ooo_second got valid=%b result=%h exp valid=11 result=%h", bus.ret_valid, bus.ret_result, {32'h33, 32'h32});
    end
    step();
    checks++;
    if (bus.ret_valid !== 2'b00 || bus.empty !== 1'b1) begin
      failures++; $display("FAIL ooo_drained got valid=%b empty=%b exp valid=00 empty=1", bus.ret_valid, bus.empty);
    end
  endtask

  task automatic test_full_wrap();
    hard_reset();
    for (int c = 0; c < 8; c++) begin drive_alloc(2'b11, 2 * c, 2 * c + 16); step(); end
    idle();
    checks++;
    if (obs_status() !== {5'd16, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL full_status got=%h exp=%h", obs_status(), {5'd16, 3'b010});
    end
    drive_alloc(2'b11, 60, 60); step();
    checks++;
    if (bus.count !== 5'd16) begin failures++; $display("FAIL full_ninth got count=%0d exp=16", bus.count); end
    idle(); drive_cmpl(0, 0, 32'hA0); drive_cmpl(1, 1, 32'hA1); step(); idle(); step();
    checks++;
    if (bus.ret_valid !== 2'b11 || bus.ret_pd !== {6'd1, 6'd0} || bus.count !== 5'd14) begin
      failures++; $display("FAIL full_retire got valid=%b pd=%h count=%0d exp valid=11 pd=1/0 count=14", bus.ret_valid, bus.ret_pd, bus.count);
    end
    checks++;
    if (bus.alloc_idx !== 8'h10 || bus.alloc_ready !== 1'b1) begin
      failures++; $display("FAIL wrap_idx got idx=%h ready=%b exp idx=10 ready=1", bus.alloc_idx, bus.alloc_ready);
    end
    drive_alloc(2'b11, 50, 52); step(); idle();
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
      failures++; $display("FAIL wrap_refill got count=%0d full=%b exp count=16 full=1", bus.count, bus.full);
    end
  endtask

  // Continues from the full buffer left by test_full_wrap (head=2, tail=2).
  task automatic test_simultaneous();
    drive_cmpl(0, 2, 32'hB2); drive_cmpl(1, 3, 32'hB3); drive_cmpl(2, 4, 32'hB4); step();
    idle(); drive_cmpl(0, 5, 32'hB5); step();
    checks++;
    if (bus.count !== 5'd14 || bus.ret_result !== {32'hB3, 32'hB2}) begin
      failures++; $display("FAIL simul_setup got count=%0d result=%h exp count=14 result=%h", bus.count, bus.ret_result, {32'hB3, 32'hB2});
    end
    idle(); drive_alloc(2'b11, 44, 46);
    drive_cmpl(0, 6, 32'hC6); drive_cmpl(1, 7, 32'hC7); drive_cmpl(2, 8, 32'hC8);
    checks++;
    if (bus.alloc_idx !== 8'h32 || bus.alloc_ready !== 1'b1) begin
      failures++; $display("FAIL simul_idx got idx=%h ready=%b exp idx=32 ready=1", bus.alloc_idx, bus.alloc_ready);
    end
    step(); idle();
    checks++;
    if (bus.count !== 5'd14 || bus.ret_result !== {32'hB5, 32'hB4}) begin
      failures++; $display("FAIL simul_count got count=%0d result=%h exp count=14 result=%h", bus.count, bus.ret_result, {32'hB5, 32'hB4});
    end
    step();
    checks++;
    if (bus.ret_valid !== 2'b11 || bus.ret_result !== {32'hC7, 32'hC6}) begin
      failures++; $display("FAIL simul_cmpl67 got valid=%b result=%h exp valid=11 result=%h", bus.ret_valid, bus.ret_result, {32'hC7, 32'hC6});
    end
    step();
    checks++;
    if (bus.ret_valid !== 2'b01 || bus.ret_result[0] !== 32'hC8) begin
      failures++; $display("FAIL simul_cmpl8 got valid=%b result0=%h exp valid=01 result0=c8", bus.ret_valid, bus.ret_result[0]);
    end
  endtask

  task automatic test_flush();
    hard_reset();
    for (int c = 0; c < 3; c++) begin drive_alloc(2'b11, 2 * c, 30); step(); end
    idle(); drive_cmpl(0, 0, 32'h70); drive_cmpl(1, 1, 32'h71); step();
    idle(); bus.flush = 1'b1; step(); idle();
    checks++;
    if (bus.ret_valid !== 2'b00 || bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      failures++; $display("FAIL flush_state got valid=%b empty=%b count=%0d exp valid=00 empty=1 count=0", bus.ret_valid, bus.empty, bus.count);
    end
    checks++;
    if (bus.alloc_idx !== 8'h10) begin failures++; $display("FAIL flush_idx got=%h exp=10", bus.alloc_idx); end
    step(); step();
    checks++;
    if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL flush_noretire got=%b exp=00", bus.ret_valid); end
  endtask

  task automatic test_reset_mid();
    hard_reset();
    for (int c = 0; c < 5; c++) begin drive_alloc(2'b11, 2 * c + 1, 40); step(); end
    idle(); drive_cmpl(0, 0, 32'h90); drive_cmpl(1, 1, 32'h91); drive_cmpl(2, 2, 32'h92); step();
    idle(); step();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (obs_status() !== {5'd0, 1'b1, 1'b0, 1'b1} || bus.alloc_idx !== 8'h10) begin
      failures++; $display("FAIL rstmid_status got status=%h idx=%h exp status=%h idx=10", obs_status(), bus.alloc_idx, {5'd0, 3'b101});
    end
    checks++;
    if ({bus.ret_valid, bus.ret_is_store, bus.ret_pd, bus.ret_old_pd, bus.ret_result} !== '0) begin
      failures++; $display("FAIL rstmid_ret got valid=%b pd=%h result=%h exp all zero", bus.ret_valid, bus.ret_pd, bus.ret_result);
    end
    drive_cmpl(0, 2, 32'hDD); step(); idle(); step(); step();
    checks++;
    if (bus.ret_valid !== 2'b00 || bus.count !== 5'd0) begin
      failures++; $display("FAIL rstmid_stale got valid=%b count=%0d exp valid=00 count=0", bus.ret_valid, bus.count);
    end
  endtask

  task automatic test_random();
    int r;
    hard_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      idle();
      r = $urandom_range(0, 3);
      bus.alloc_valid    = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      bus.alloc_is_store = ($urandom_range(0, 3) == 0) ? {DEST_MEM, DEST_REG} : {DEST_REG, DEST_REG};
      for (int i = 0; i < ALLOC_W; i++) begin
        bus.alloc_pd[i]     = 6'($urandom);
        bus.alloc_old_pd[i] = 6'($urandom);
      end
      for (int l = 0; l < CMPL_W; l++)
        if ($urandom_range(0, 2) != 0 && mq.size() > 0) begin
          bus.cmpl_valid[l]  = 1'b1;
          bus.cmpl_idx[l]    = 4'((mhead + $urandom_range(0, mq.size() - 1)) % DEPTH);
          bus.cmpl_result[l] = $urandom;
        end
      bus.flush = ($urandom_range(0, 99) == 0);
      checks++;
      if (bus.alloc_idx !== exp_aidx()) begin
        failures++; $display("FAIL rand_alloc_idx cyc=%0d got=%h exp=%h", cyc, bus.alloc_idx, exp_aidx());
      end
      step();
      checks++;
      if (obs_status() !== exp_status()) begin
        failures++; $display("FAIL rand_status cyc=%0d got=%h exp=%h", cyc, obs_status(), exp_status());
      end
      checks++;
      if (obs_ret() !== exp_ret_pkt()) begin
        failures++; $display("FAIL rand_ret cyc=%0d got=%h exp=%h", cyc, obs_ret(), exp_ret_pkt());
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
